// File: rtl/acc_pkg.sv
// acc_pkg: write-mode constants, drain FSM states and the
// sign-extend / saturating-add helpers shared by the accumulator buffer.
package acc_pkg;

  localparam logic ACC      = 1'b0;
  localparam logic OVR      = 1'b1;
  localparam logic CACC_OVR = 1'b0;
  localparam logic CACC_ADD = 1'b1;

  // Helpers work on a wide scratch word; operands must be < XW-1 bits.
  localparam int unsigned XW = 64;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT,
    DONE
  } drain_state_e;

  typedef struct packed {
    logic          ovf;
    logic [XW-1:0] sum;
  } sat_res_t;

  function automatic logic [XW-1:0] sext(
    input logic [XW-1:0] x,
    input int unsigned   w
  );
    logic signed [XW-1:0] t;
    t = $signed(x << (XW - w));
    return t >>> (XW - w);
  endfunction

  function automatic sat_res_t sat_add(
    input logic [XW-1:0] a,
    input logic [XW-1:0] b,
    input int unsigned   w
  );
    logic signed [XW-1:0] s;
    logic signed [XW-1:0] mx;
    logic signed [XW-1:0] mn;
    sat_res_t r;
    s = $signed(a) + $signed(b);
    mx = $signed((64'd1 << (w - 1)) - 64'd1);
    mn = -$signed(64'd1 << (w - 1));
    r.ovf = 1'b0;
    r.sum = s;
    if (s > mx) begin
      r.ovf = 1'b1;
      r.sum = mx;
    end else if (s < mn) begin
      r.ovf = 1'b1;
      r.sum = mn;
    end
    return r;
  endfunction

endpackage

// File: rtl/acc_col_update.sv
// acc_col_update: next value of one column of one row, applying the
// array write first and the compensation write second, with saturation.
module acc_col_update
  import acc_pkg::*;
#(
  parameter int PSUM_W  = 45,
  parameter int CPSUM_W = 14
) (
  input  logic [PSUM_W-1:0]  mem_val,
  input  logic               clr,
  input  logic               acc_hit,
  input  logic               acc_mode,
  input  logic [PSUM_W-1:0]  psum,
  input  logic               cacc_hit,
  input  logic               cacc_mode,
  input  logic [CPSUM_W-1:0] cpsum,
  output logic [PSUM_W-1:0]  new_val,
  output logic               ovf
);

  logic [PSUM_W-1:0] base;
  logic [PSUM_W-1:0] a_val;
  logic [XW-1:0]     cp_x;
  sat_res_t          r_acc;
  sat_res_t          r_cacc;

  always_comb begin
    base   = clr ? '0 : mem_val;
    cp_x   = sext(XW'(cpsum), CPSUM_W);
    r_acc  = sat_add(sext(XW'(base), PSUM_W),
                     sext(XW'(psum), PSUM_W), PSUM_W);
    a_val  = base;
    ovf    = 1'b0;
    if (acc_hit) begin
      if (acc_mode == OVR) begin
        a_val = psum;
      end else begin
        a_val = r_acc.sum[PSUM_W-1:0];
        ovf   = r_acc.ovf;
      end
    end
    r_cacc  = sat_add(sext(XW'(a_val), PSUM_W), cp_x, PSUM_W);
    new_val = a_val;
    if (cacc_hit) begin
      if (cacc_mode == CACC_ADD) begin
        new_val = r_cacc.sum[PSUM_W-1:0];
        ovf     = ovf | r_cacc.ovf;
      end else begin
        new_val = cp_x[PSUM_W-1:0];
      end
    end
  end

endmodule

// File: rtl/acc_buffer.sv
// acc_buffer: DEPTH x COLS signed partial-sum store with two write ports,
// saturating update and a handshaked, optionally clearing, row drain engine.
module acc_buffer
  import acc_pkg::*;
#(
  parameter int COLS        = 8,
  parameter int DEPTH       = 8,
  parameter int PSUM_W      = 45,
  parameter int CPSUM_W     = 14,
  parameter int CLR_ON_READ = 1,
  parameter int ADDR_W      = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      acc_wr_en,
  input  logic [ADDR_W-1:0]         acc_wr_addr,
  input  logic                      acc_wr_mode,
  input  logic [COLS*PSUM_W-1:0]    psum_in,
  input  logic                      cacc_wr_en,
  input  logic [ADDR_W-1:0]         cacc_wr_addr,
  input  logic                      cacc_mode,
  input  logic [COLS*CPSUM_W-1:0]   cpsum_in,
  input  logic                      drain_start,
  input  logic [ADDR_W-1:0]         drain_base,
  input  logic [ADDR_W:0]           drain_len,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_W-1:0]         out_addr,
  output logic [COLS*PSUM_W-1:0]    out_data,
  output logic                      drain_busy,
  output logic                      drain_done,
  output logic                      ovf_flag
);

  localparam int RW = COLS * PSUM_W;
  localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

  drain_state_e      state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] ptr_nxt;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [RW-1:0]     out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              drain_busy_q, drain_busy_d;
  logic              drain_done_q, drain_done_d;
  logic              ovf_q, ovf_d;
  logic [RW-1:0]     mem_q [DEPTH];
  logic [RW-1:0]     mem_d [DEPTH];
  logic [DEPTH-1:0]  row_ovf;
  logic              hs;

  assign hs      = (state_q == PRESENT) && out_ready;
  assign ptr_nxt = ptr_q + 1'b1;

  for (genvar r = 0; r < DEPTH; r++) begin : g_row
    logic [COLS-1:0] col_ovf;
    logic [RW-1:0]   row_d;
    logic            clr_r;
    logic            acc_hit_r;
    logic            cacc_hit_r;

    assign clr_r      = (CLR_ON_READ != 0) && hs &&
                        (ptr_q == ADDR_W'(r));
    assign acc_hit_r  = acc_wr_en && (acc_wr_addr == ADDR_W'(r));
    assign cacc_hit_r = cacc_wr_en && (cacc_wr_addr == ADDR_W'(r));

    for (genvar c = 0; c < COLS; c++) begin : g_col
      acc_col_update #(
        .PSUM_W (PSUM_W),
        .CPSUM_W(CPSUM_W)
      ) u_col (
        .mem_val  (mem_q[r][c*PSUM_W +: PSUM_W]),
        .clr      (clr_r),
        .acc_hit  (acc_hit_r),
        .acc_mode (acc_wr_mode),
        .psum     (psum_in[c*PSUM_W +: PSUM_W]),
        .cacc_hit (cacc_hit_r),
        .cacc_mode(cacc_mode),
        .cpsum    (cpsum_in[c*CPSUM_W +: CPSUM_W]),
        .new_val  (row_d[c*PSUM_W +: PSUM_W]),
        .ovf      (col_ovf[c])
      );
    end

    assign mem_d[r]   = row_d;
    assign row_ovf[r] = |col_ovf;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    ovf_d      = ovf_q | (|row_ovf);
    unique case (state_q)
      IDLE: begin
        if (drain_start) begin
          state_d = FETCH;
          ptr_d   = drain_base;
          rem_d   = (drain_len == '0 || drain_len > FULL) ?
                    FULL : drain_len;
          ovf_d   = |row_ovf;
        end
      end
      FETCH: begin
        out_data_d = mem_q[ptr_q];
        out_addr_d = ptr_q;
        state_d    = PRESENT;
      end
      PRESENT: begin
        if (out_ready) begin
          // Prefetch the next row so a ready consumer sees 1 row/cycle.
          if (rem_q > (ADDR_W + 1)'(1)) begin
            rem_d      = rem_q - 1'b1;
            ptr_d      = ptr_nxt;
            out_data_d = mem_q[ptr_nxt];
            out_addr_d = ptr_nxt;
          end else begin
            rem_d   = '0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    out_valid_d  = (state_d == PRESENT);
    drain_busy_d = (state_d != IDLE);
    drain_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      rem_q        <= '0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      drain_busy_q <= 1'b0;
      drain_done_q <= 1'b0;
      ovf_q        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      rem_q        <= rem_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      drain_busy_q <= drain_busy_d;
      drain_done_q <= drain_done_d;
      ovf_q        <= ovf_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_addr   = out_addr_q;
  assign out_data   = out_data_q;
  assign drain_busy = drain_busy_q;
  assign drain_done = drain_done_q;
  assign ovf_flag   = ovf_q;

endmodule

// File: tb/tb_acc_buffer.sv
// tb_acc_buffer: directed scenarios for acc_buffer with
// hand-computed expected row contents, addresses and flags.
module tb_acc_buffer;

  localparam int COLS = 8;
  localparam int DEPTH = 8;
  localparam int PW = 45;
  localparam int CW = 14;
  localparam int AW = 3;
  localparam longint PMAX = (64'sd1 <<< 44) - 64'sd1;
  localparam longint PMIN = -(64'sd1 <<< 44);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic acc_wr_en = 1'b0;
  logic [AW-1:0] acc_wr_addr = '0;
  logic acc_wr_mode = 1'b0;
  logic [COLS*PW-1:0] psum_in = '0;
  logic cacc_wr_en = 1'b0;
  logic [AW-1:0] cacc_wr_addr = '0;
  logic cacc_mode = 1'b0;
  logic [COLS*CW-1:0] cpsum_in = '0;
  logic drain_start = 1'b0;
  logic [AW-1:0] drain_base = '0;
  logic [AW:0] drain_len = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [AW-1:0] out_addr;
  logic [COLS*PW-1:0] out_data;
  logic drain_busy;
  logic drain_done;
  logic ovf_flag;

  logic [COLS*PW-1:0] got_row [8];
  logic [AW-1:0] got_addr [8];
  int got_cyc [8];
  int done_cnt;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  acc_buffer #(
    .COLS(COLS), .DEPTH(DEPTH), .PSUM_W(PW),
    .CPSUM_W(CW), .CLR_ON_READ(1)
  ) dut (
    .clk(clk), .rst(rst),
    .acc_wr_en(acc_wr_en), .acc_wr_addr(acc_wr_addr),
    .acc_wr_mode(acc_wr_mode), .psum_in(psum_in),
    .cacc_wr_en(cacc_wr_en), .cacc_wr_addr(cacc_wr_addr),
    .cacc_mode(cacc_mode), .cpsum_in(cpsum_in),
    .drain_start(drain_start), .drain_base(drain_base),
    .drain_len(drain_len), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .drain_busy(drain_busy),
    .drain_done(drain_done), .ovf_flag(ovf_flag)
  );

  function automatic longint colv(input logic [COLS*PW-1:0] row, input int c);
    logic signed [PW-1:0] v;
    v = row[c*PW +: PW];
    return longint'(v);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic ae, input logic [AW-1:0] aa, input logic am,
                    input int ac, input longint av,
                    input logic ce, input logic [AW-1:0] ca, input logic cm,
                    input int cc, input int cv);
    psum_in = '0;
    cpsum_in = '0;
    psum_in[ac*PW +: PW] = PW'(av);
    cpsum_in[cc*CW +: CW] = CW'(cv);
    acc_wr_en = ae; acc_wr_addr = aa; acc_wr_mode = am;
    cacc_wr_en = ce; cacc_wr_addr = ca; cacc_mode = cm;
    cyc();
    acc_wr_en = 1'b0;
    cacc_wr_en = 1'b0;
    psum_in = '0;
    cpsum_in = '0;
  endtask

  task automatic aw(input logic [AW-1:0] a, input logic m, input int c, input longint v);
    wr(1'b1, a, m, c, v, 1'b0, '0, 1'b0, 0, 0);
  endtask

  task automatic cw(input logic [AW-1:0] a, input logic m, input int c, input int v);
    wr(1'b0, '0, 1'b0, 0, 0, 1'b1, a, m, c, v);
  endtask

  task automatic drain_rows(input logic [AW-1:0] base, input logic [AW:0] len,
                            input int n, output bit ok);
    int k;
    int t;
    drain_base = base; drain_len = len;
    drain_start = 1'b1; out_ready = 1'b1;
    cyc();
    drain_start = 1'b0;
    k = 0; t = 0;
    while (k < n && t < 40) begin
      if (out_valid) begin
        got_row[k] = out_data; got_addr[k] = out_addr; got_cyc[k] = t;
        k++;
      end
      cyc();
      t++;
    end
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (drain_done) done_cnt++;
      cyc();
    end
    out_ready = 1'b0;
    ok = (k == n);
  endtask

  task automatic test_reset();
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    total++; if (drain_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", drain_busy); end
    total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", drain_done); end
    total++; if (ovf_flag !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", ovf_flag); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL rst_data got=%h exp=0", out_data); end
    total++; if (out_addr !== 3'd0) begin bad++; $display("FAIL rst_addr got=%0d exp=0", out_addr); end
  endtask

  task automatic test_row_update();
    bit ok;
    aw(3, 1'b1, 0, 100);
    aw(3, 1'b0, 0, -30);
    cw(3, 1'b1, 0, 5);
    drain_rows(3, 1, 1, ok);
    total++; if (!ok) begin bad++; $display("FAIL row3_timeout got=0 exp=1"); end
    total++; if (colv(got_row[0], 0) !== 75) begin bad++; $display("FAIL row3_val got=%0d exp=75", colv(got_row[0], 0)); end
    total++; if (got_addr[0] !== 3'd3) begin bad++; $display("FAIL row3_addr got=%0d exp=3", got_addr[0]); end
    total++; if (got_cyc[0] !== 1) begin bad++; $display("FAIL latency got=%0d exp=1", got_cyc[0]); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL row3_done got=%0d exp=1", done_cnt); end
    drain_rows(3, 1, 1, ok);
    total++; if (!ok || colv(got_row[0], 0) !== 0) begin bad++; $display("FAIL row3_clr got=%0d exp=0", colv(got_row[0], 0)); end
  endtask

  task automatic test_collision();
    bit ok;
    aw(2, 1'b1, 0, 10);
    wr(1'b1, 2, 1'b0, 0, 7, 1'b1, 2, 1'b0, 0, -4);
    drain_rows(2, 1, 1, ok);
    total++; if (!ok || colv(got_row[0], 0) !== -4) begin bad++; $display("FAIL coll_ovr got=%0d exp=-4", colv(got_row[0], 0)); end
    aw(2, 1'b1, 0, 10);
    wr(1'b1, 2, 1'b0, 0, 7, 1'b1, 2, 1'b1, 0, -4);
    drain_rows(2, 1, 1, ok);
    total++; if (!ok || colv(got_row[0], 0) !== 13) begin bad++; $display("FAIL coll_add got=%0d exp=13", colv(got_row[0], 0)); end
    wr(1'b1, 4, 1'b1, 0, 50, 1'b1, 5, 1'b0, 0, -7);
    drain_rows(4, 2, 2, ok);
    total++; if (!ok || colv(got_row[0], 0) !== 50) begin bad++; $display("FAIL indep_acc got=%0d exp=50", colv(got_row[0], 0)); end
    total++; if (colv(got_row[1], 0) !== -7) begin bad++; $display("FAIL indep_cacc got=%0d exp=-7", colv(got_row[1], 0)); end
    total++; if (got_addr[1] !== 3'd5) begin bad++; $display("FAIL indep_addr got=%0d exp=5", got_addr[1]); end
  endtask

  task automatic test_saturation();
    bit ok;
    aw(0, 1'b1, 1, PMAX - 1);
    aw(0, 1'b0, 1, 5);
    total++; if (ovf_flag !== 1'b1) begin bad++; $display("FAIL sat_hi_flag got=%b exp=1", ovf_flag); end
    drain_rows(0, 1, 1, ok);
    total++; if (!ok || colv(got_row[0], 1) !== PMAX) begin bad++; $display("FAIL sat_hi got=%0d exp=%0d", colv(got_row[0], 1), PMAX); end
    total++; if (colv(got_row[0], 0) !== 0) begin bad++; $display("FAIL sat_col0 got=%0d exp=0", colv(got_row[0], 0)); end
    total++; if (ovf_flag !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", ovf_flag); end
    aw(0, 1'b0, 1, 5);
    total++; if (ovf_flag !== 1'b0) begin bad++; $display("FAIL ovf_nosat got=%b exp=0", ovf_flag); end
    aw(0, 1'b1, 1, PMIN);
    aw(0, 1'b0, 1, -1);
    total++; if (ovf_flag !== 1'b1) begin bad++; $display("FAIL sat_lo_flag got=%b exp=1", ovf_flag); end
    drain_rows(0, 1, 1, ok);
    total++; if (!ok || colv(got_row[0], 1) !== PMIN) begin bad++; $display("FAIL sat_lo got=%0d exp=%0d", colv(got_row[0], 1), PMIN); end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [AW-1:0] ea [4];
    longint ev [4];
    ea[0] = 3'd6; ea[1] = 3'd7; ea[2] = 3'd0; ea[3] = 3'd1;
    ev[0] = 61; ev[1] = 71; ev[2] = 1; ev[3] = 11;
    for (int i = 0; i < 4; i++) aw(ea[i], 1'b1, 0, ev[i]);
    drain_rows(6, 4, 4, ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_timeout got=0 exp=1"); end
    for (int i = 0; i < 4; i++) begin
      total++; if (got_addr[i] !== ea[i]) begin bad++; $display("FAIL wrap_addr%0d got=%0d exp=%0d", i, got_addr[i], ea[i]); end
      total++; if (colv(got_row[i], 0) !== ev[i]) begin bad++; $display("FAIL wrap_data%0d got=%0d exp=%0d", i, colv(got_row[i], 0), ev[i]); end
      total++; if (got_cyc[i] !== i + 1) begin bad++; $display("FAIL wrap_cyc%0d got=%0d exp=%0d", i, got_cyc[i], i + 1); end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL wrap_done got=%0d exp=1", done_cnt); end
    total++; if (drain_busy !== 1'b0) begin bad++; $display("FAIL wrap_busy got=%b exp=0", drain_busy); end
  endtask

  task automatic test_reset_mid_drain();
    bit ok;
    int t;
    for (int r = 0; r < DEPTH; r++) aw(AW'(r), 1'b1, 0, r + 1);
    drain_base = 0; drain_len = 5; drain_start = 1'b1; out_ready = 1'b0;
    cyc();
    drain_start = 1'b0;
    t = 0;
    while (!out_valid && t < 10) begin cyc(); t++; end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_present got=%b exp=1", out_valid); end
    #2 rst = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
    total++; if (drain_busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", drain_busy); end
    rst = 1'b0;
    cyc();
    drain_rows(0, 0, 8, ok);
    total++; if (!ok) begin bad++; $display("FAIL full_timeout got=0 exp=1"); end
    for (int r = 0; r < DEPTH; r++) begin
      total++; if (colv(got_row[r], 0) !== 0 || got_addr[r] !== AW'(r)) begin
        bad++; $display("FAIL full_row%0d got=%0d@%0d exp=0@%0d", r, colv(got_row[r], 0), got_addr[r], r);
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    int t;
    aw(5, 1'b1, 0, 33);
    aw(6, 1'b1, 0, 66);
    drain_base = 5; drain_len = 2; drain_start = 1'b1; out_ready = 1'b0;
    cyc();
    drain_start = 1'b0;
    t = 0;
    while (!out_valid && t < 10) begin cyc(); t++; end
    for (int i = 0; i < 3; i++) begin
      psum_in = '0;
      psum_in[0 +: PW] = PW'(99);
      acc_wr_en = (i == 0); acc_wr_addr = 5; acc_wr_mode = 1'b1;
      drain_start = 1'b1; drain_base = 0; drain_len = 1;
      cyc();
      acc_wr_en = 1'b0; drain_start = 1'b0; psum_in = '0;
      total++; if (out_valid !== 1'b1 || out_addr !== 3'd5) begin bad++; $display("FAIL stall_addr%0d got=%0d exp=5", i, out_addr); end
      total++; if (colv(out_data, 0) !== 33) begin bad++; $display("FAIL stall_data%0d got=%0d exp=33", i, colv(out_data, 0)); end
    end
    out_ready = 1'b1;
    cyc();
    total++; if (out_addr !== 3'd6 || colv(out_data, 0) !== 66) begin bad++; $display("FAIL stall_next got=%0d@%0d exp=66@6", colv(out_data, 0), out_addr); end
    cyc();
    total++; if (drain_done !== 1'b1) begin bad++; $display("FAIL stall_done got=%b exp=1", drain_done); end
    cyc();
    out_ready = 1'b0;
    total++; if (drain_busy !== 1'b0) begin bad++; $display("FAIL stall_busy got=%b exp=0", drain_busy); end
    drain_rows(5, 1, 1, ok);
    total++; if (!ok || colv(got_row[0], 0) !== 0) begin bad++; $display("FAIL stall_clr got=%0d exp=0", colv(got_row[0], 0)); end
  endtask

  initial begin
    test_reset();
    test_row_update();
    test_collision();
    test_saturation();
    test_wrap();
    test_reset_mid_drain();
    test_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
